// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 key events to held game-control levels and a timed coin pulse
module ps2_key_decoder #(
  parameter int COIN_CYCLES = 2400000,
  parameter int CNT_W       = 22
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [10:0] ps2_key,
  output logic        joy_up,
  output logic        joy_down,
  output logic        joy_left,
  output logic        joy_right,
  output logic        fire,
  output logic        start1,
  output logic        start2,
  output logic        coin,
  output logic        key_stb,
  output logic [9:0]  key_last
);

  logic             tog_q;
  logic             evt;
  logic             pressed;
  logic             ext;
  logic [7:0]       code;
  logic             up_raw, dn_raw, lt_raw, rt_raw;
  logic             last_dn, last_rt;
  logic             fire_l, fire_r;
  logic             start1_q, start2_q;
  logic [CNT_W-1:0] coin_cnt;

  assign evt     = ps2_key[10] != tog_q;
  assign pressed = ps2_key[9];
  assign ext     = ps2_key[8];
  assign code    = ps2_key[7:0];

  // With both raw bits held, last_* selects the most recently pressed direction.
  assign joy_up    = up_raw & (~dn_raw | ~last_dn);
  assign joy_down  = dn_raw & (~up_raw |  last_dn);
  assign joy_left  = lt_raw & (~rt_raw | ~last_rt);
  assign joy_right = rt_raw & (~lt_raw |  last_rt);
  assign fire      = fire_l | fire_r;
  assign start1    = start1_q;
  assign start2    = start2_q;
  assign coin      = coin_cnt != '0;

  always_ff @(posedge clk_sys) begin
    tog_q <= ps2_key[10];
    if (!reset_n) begin
      key_stb  <= 1'b0;
      key_last <= '0;
      up_raw   <= 1'b0;
      dn_raw   <= 1'b0;
      lt_raw   <= 1'b0;
      rt_raw   <= 1'b0;
      last_dn  <= 1'b0;
      last_rt  <= 1'b0;
      fire_l   <= 1'b0;
      fire_r   <= 1'b0;
      start1_q <= 1'b0;
      start2_q <= 1'b0;
      coin_cnt <= '0;
    end else begin
      key_stb <= evt;
      if (coin_cnt != '0)
        coin_cnt <= coin_cnt - CNT_W'(1);
      if (evt) begin
        key_last <= ps2_key[9:0];
        if (ext) begin
          // Only a fresh press claims "last pressed", so typematic repeats change nothing.
          case (code)
            8'h75: begin
              if (pressed && !up_raw) last_dn <= 1'b0;
              up_raw <= pressed;
            end
            8'h72: begin
              if (pressed && !dn_raw) last_dn <= 1'b1;
              dn_raw <= pressed;
            end
            8'h6B: begin
              if (pressed && !lt_raw) last_rt <= 1'b0;
              lt_raw <= pressed;
            end
            8'h74: begin
              if (pressed && !rt_raw) last_rt <= 1'b1;
              rt_raw <= pressed;
            end
            8'h14:   fire_r <= pressed;
            default: ;
          endcase
        end else begin
          case (code)
            8'h14: fire_l   <= pressed;
            8'h16: start1_q <= pressed;
            8'h1E: start2_q <= pressed;
            8'h2E: begin
              // A running pulse is neither restarted nor extended.
              if (pressed && coin_cnt == '0)
                coin_cnt <= CNT_W'(COIN_CYCLES);
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb/tb_ps2_key_decoder.sv - self-checking bench for ps2_key_decoder
module tb_ps2_key_decoder;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic [10:0] ps2_key = 11'h400;
  logic        joy_up, joy_down, joy_left, joy_right;
  logic        fire, start1, start2, coin, key_stb;
  logic [9:0]  key_last;
  logic [7:0]  outs;
  logic        tog = 1'b1;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  ps2_key_decoder #(.COIN_CYCLES(8), .CNT_W(4)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .ps2_key  (ps2_key),
    .joy_up   (joy_up),
    .joy_down (joy_down),
    .joy_left (joy_left),
    .joy_right(joy_right),
    .fire     (fire),
    .start1   (start1),
    .start2   (start2),
    .coin     (coin),
    .key_stb  (key_stb),
    .key_last (key_last)
  );

  always #5 clk_sys = ~clk_sys;

  assign outs = {joy_up, joy_down, joy_left, joy_right, fire, start1, start2, coin};

  // Scoreboard: every strobe must match the oldest pending event.
  always @(negedge clk_sys) begin
    if (key_stb === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_stb: key_last=%h with no pending event", key_last);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (key_last !== e) begin
          bad++;
          $display("FAIL key_last: got %h expected %h", key_last, e);
        end
      end
    end
  end

  task automatic send(input bit p, input bit e, input logic [7:0] c);
    tog = ~tog;
    ps2_key = {tog, p, e, c};
    exp_q.push_back({p, e, c});
    @(posedge clk_sys); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk_sys); #1; end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    ps2_key = 11'h400;
    tog = 1'b1;
    idle(3);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      total++;
      if (outs !== 8'h00 || key_stb !== 1'b0) begin
        bad++;
        $display("FAIL reset_idle[%0d]: outs=%b stb=%b expected 00000000/0", i, outs, key_stb);
      end
      idle(1);
    end
  endtask

  task automatic test_up;
    send(1, 1, 8'h75);
    total++;
    if (outs !== 8'b1000_0000 || key_stb !== 1'b1 || key_last !== 10'h375) begin
      bad++;
      $display("FAIL up_press: outs=%b stb=%b last=%h expected 10000000/1/375", outs, key_stb, key_last);
    end
    idle(1);
    total++;
    if (key_stb !== 1'b0) begin
      bad++;
      $display("FAIL stb_width: stb=%b expected 0", key_stb);
    end
    send(0, 1, 8'h75);
    total++;
    if (outs !== 8'h00) begin
      bad++;
      $display("FAIL up_release: outs=%b expected 00000000", outs);
    end
  endtask

  task automatic test_opposing;
    send(1, 1, 8'h6B);
    total++;
    if (outs !== 8'b0010_0000) begin bad++; $display("FAIL lr_left: outs=%b expected 00100000", outs); end
    send(1, 1, 8'h74);
    total++;
    if (outs !== 8'b0001_0000) begin bad++; $display("FAIL lr_right_wins: outs=%b expected 00010000", outs); end
    send(0, 1, 8'h74);
    total++;
    if (outs !== 8'b0010_0000) begin bad++; $display("FAIL lr_left_back: outs=%b expected 00100000", outs); end
    send(0, 1, 8'h6B);
    total++;
    if (outs !== 8'h00) begin bad++; $display("FAIL lr_none: outs=%b expected 00000000", outs); end
    // up/down pair with a typematic repeat of the winner
    send(1, 1, 8'h75);
    send(1, 1, 8'h72);
    send(1, 1, 8'h72);
    total++;
    if (outs !== 8'b0100_0000) begin bad++; $display("FAIL ud_down_wins: outs=%b expected 01000000", outs); end
    send(0, 1, 8'h72);
    total++;
    if (outs !== 8'b1000_0000) begin bad++; $display("FAIL ud_up_back: outs=%b expected 10000000", outs); end
    send(0, 1, 8'h75);
  endtask

  task automatic test_coin;
    send(1, 0, 8'h2E);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (coin !== 1'b1) begin bad++; $display("FAIL coin_high[%0d]: coin=%b expected 1", i, coin); end
      if (i == 2) send(1, 0, 8'h2E);
      else idle(1);
    end
    total++;
    if (coin !== 1'b0) begin bad++; $display("FAIL coin_fall: coin=%b expected 0", coin); end
    send(0, 0, 8'h2E);
    total++;
    if (coin !== 1'b0) begin bad++; $display("FAIL coin_release: coin=%b expected 0", coin); end
    send(1, 0, 8'h2E);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (coin !== 1'b1) begin bad++; $display("FAIL coin2_high[%0d]: coin=%b expected 1", i, coin); end
      idle(1);
    end
    total++;
    if (coin !== 1'b0) begin bad++; $display("FAIL coin2_fall: coin=%b expected 0", coin); end
    send(0, 0, 8'h2E);
  endtask

  task automatic test_fire_unmapped;
    send(1, 0, 8'h14);
    send(1, 1, 8'h14);
    send(0, 0, 8'h14);
    total++;
    if (outs !== 8'b0000_1000) begin bad++; $display("FAIL fire_held: outs=%b expected 00001000", outs); end
    send(0, 1, 8'h14);
    total++;
    if (outs !== 8'h00) begin bad++; $display("FAIL fire_off: outs=%b expected 00000000", outs); end
    send(1, 0, 8'h75);
    total++;
    if (outs !== 8'h00 || key_stb !== 1'b1) begin
      bad++;
      $display("FAIL kp8_unmapped: outs=%b stb=%b expected 00000000/1", outs, key_stb);
    end
    send(0, 0, 8'h75);
    send(1, 0, 8'h1E);
    total++;
    if (outs !== 8'b0000_0001 << 1) begin bad++; $display("FAIL start2: outs=%b expected 00000010", outs); end
    send(0, 0, 8'h1E);
  endtask

  task automatic test_reset_mid;
    send(1, 0, 8'h16);
    send(1, 1, 8'h75);
    total++;
    if (outs !== 8'b1000_0100) begin bad++; $display("FAIL held_pre_reset: outs=%b expected 10000100", outs); end
    reset_n = 1'b0;
    tog = ~tog;
    ps2_key = {tog, 1'b1, 1'b0, 8'h2E};
    idle(1);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (outs !== 8'h00 || key_stb !== 1'b0) begin
        bad++;
        $display("FAIL reset_mid[%0d]: outs=%b stb=%b expected 00000000/0", i, outs, key_stb);
      end
      idle(1);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_opposing();
    test_coin();
    test_fire_unmapped();
    test_reset_mid();
    idle(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_events: %0d events never strobed, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
